alu_input_sequencer: RTL
========================

# alu_input_sequencer

Upstream front end for the ALU on the FPGA board: turns raw push-buttons and switches into clean, registered ALU operands and an opcode. Debounces the keys, then walks the user through a load-A / load-B / load-opcode / execute sequence. Drives port_A, port_B and ALUOP of the ALU interface and flags each new computation with a one-cycle pulse, so the display stage updates only on deliberate operations.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable samples required before a key level is accepted; minimum 2.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width.

Ports:
- CLOCK_50  in  1  system clock; single clock domain; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- KEY  in  4  raw push-buttons, active-low, asynchronous to CLOCK_50.
- SW  in  18  raw switches; SW[15:0] operand data, SW[16] sign-fill select, SW[3:0] opcode in the LOAD_OP state.
- port_A  out  32  registered operand A.
- port_B  out  32  registered operand B.
- ALUOP  out  4  registered ALU opcode.
- exec_valid  out  1  one-cycle pulse: operands and opcode are committed.
- state_led  out  4  one-hot current state, for LEDR: bit 0 LOAD_A, bit 1 LOAD_B, bit 2 LOAD_OP, bit 3 SHOW.

## Operation
- Input conditioning: each KEY bit and SW[16:0] pass through a 2-flop synchronizer.
- Debounce: each KEY bit is debounced independently. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current debounced level. The counter clears on any sample that equals the current level.
- Press event: one-cycle pulse on the debounced falling edge (key pressed). KEY[0] = advance, KEY[1] = cancel; KEY[3:2] are ignored.
- Operand value: {SW[16] ? 16'hFFFF : 16'h0000, SW[15:0]}, taken from the synchronized switches.
- FSM states: LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW.
  - LOAD_A + advance: port_A <= operand value; go to LOAD_B.
  - LOAD_B + advance: port_B <= operand value; go to LOAD_OP.
  - LOAD_OP + advance: ALUOP <= SW[3:0]; go to EXEC.
  - EXEC: exec_valid = 1 for exactly this cycle; go to SHOW unconditionally.
  - SHOW + advance: go to LOAD_A. port_A, port_B and ALUOP hold so the result stays displayed.
- Cancel in any state except EXEC: go to LOAD_A; port_A, port_B and ALUOP clear to 0.
- Cancel during EXEC: deferred one cycle. It is evaluated in SHOW, so the exec pulse is never truncated.
- Advance and cancel in the same cycle: cancel wins.
- Outputs hold their values between load events; switch movement alone never changes any output.
- state_led in EXEC: 4'b1000 (same as SHOW).

## Timing
- Reset values: port_A = 0, port_B = 0, ALUOP = 0, exec_valid = 0, state_led = 4'b0001, FSM = LOAD_A, debounced levels = released, counters = 0, synchronizers = released (KEY) / 0 (SW).
- Key-press latency: a raw press held stable from cycle 0 produces its event pulse in cycle DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES + 1 edge). The resulting register and state update is visible in the following cycle.
- A press held indefinitely produces exactly one event. A new event requires a debounced release followed by a press.
- Glitches shorter than DEBOUNCE_CYCLES samples produce no event.
- Switch-to-operand latency: 2 cycles through the synchronizer. The sampled value is the synchronized SW at the event cycle.
- exec_valid: high exactly one cycle per completed sequence. It is never high in consecutive cycles.
- Reset asserted mid-sequence or mid-debounce: on the next clock edge, all state returns to the reset values. An in-progress press must be fully re-debounced after reset deasserts.

## Structure
- Shared package: FSM state enum (LOAD_A..SHOW), opcode width constant, and the sign-fill constants 16'hFFFF / 16'h0000. ALUOP is typed with the existing ALU opcode type from the team's shared types package.
- Sub-module: key_debounce, one instance per used key. It contains the synchronizer, counter and falling-edge pulse, and is parameterized by DEBOUNCE_CYCLES.
- The top contains the switch synchronizer, operand formation, FSM and output registers.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4.
- Full sequence: SW = 0x00005, then 0x1FFFE, then opcode 0x2, each followed by an advance press held for 10 cycles. Required: port_A = 0x00000005, port_B = 0xFFFFFFFE, ALUOP = 2, exactly one exec_valid pulse, state_led = 4'b1000 after the pulse.
- Bounce: KEY[0] toggles every 2 cycles for 20 cycles, then settles released. Required: no event, state_led stays 4'b0001, outputs stay 0.
- Held key: KEY[0] held low for 200 cycles in LOAD_A. Required: exactly one transition, to LOAD_B; the second press then moves to LOAD_OP.
- Cancel priority: KEY[0] and KEY[1] pressed on the same cycle in LOAD_OP with port_A = 5. Required: state_led = 4'b0001 and port_A = port_B = ALUOP = 0.
- Reset mid-operation: assert rst for 1 cycle while in LOAD_OP with a key half-debounced. Required: all outputs at reset values the next cycle, and no spurious event after rst deasserts until a full new press is debounced.
- Switch isolation: in SHOW, toggle SW[15:0] freely. Required: port_A, port_B and ALUOP unchanged and exec_valid stays 0.

Source files
------------

// File: rtl/alu_input_sequencer_pkg.sv
// Shared types and constants for the ALU input sequencer: FSM states,
// opcode type and the sign-fill patterns used to widen 16-bit operands.
package alu_input_sequencer_pkg;

    localparam int OPCODE_W = 4;

    // ALU opcode as seen on the ALU interface
    typedef logic [OPCODE_W-1:0] alu_op_t;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } seq_state_t;

    localparam logic [15:0] SIGN_FILL_ONES  = 16'hFFFF;
    localparam logic [15:0] SIGN_FILL_ZEROS = 16'h0000;

    // Bit 16 selects the upper-half fill, bits 15:0 are the operand data
    function automatic logic [31:0] form_operand(input logic [16:0] sw);
        return {(sw[16] ? SIGN_FILL_ONES : SIGN_FILL_ZEROS), sw[15:0]};
    endfunction

endpackage

// File: rtl/alu_input_sequencer_key_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and a registered
// one-cycle pulse on the debounced press (falling) edge. Keys are active-low.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic key_n_i,
    output logic press_o
);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchronizer, debounce state and press-edge pulse registers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_q      <= 2'b11;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            cnt_q       <= '0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_n_i};
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            press_q     <= level_dly_q & ~level_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Board front end for the ALU: debounced advance/cancel keys drive a
// load-A / load-B / load-opcode / execute sequence that registers the
// operands and opcode and flags each committed computation with a pulse.
module alu_input_sequencer
    import alu_input_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [31:0] port_A,
    output logic [31:0] port_B,
    output alu_op_t     ALUOP,
    output logic        exec_valid,
    output logic [3:0]  state_led
);

    localparam int N_KEYS = 2;   // KEY[0] advance, KEY[1] cancel

    logic [N_KEYS-1:0] press;
    logic [16:0]       sw_meta_q, sw_sync_q;
    seq_state_t        state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    alu_op_t           op_q, op_d;
    logic              cancel_pend_q, cancel_pend_d;
    logic              advance, cancel;
    logic              unused_inputs;

    // KEY[3:2] and SW[17] have no function in this design
    assign unused_inputs = &{1'b0, KEY[3:2], SW[17]};

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_key_debounce (
                .clk_i  (CLOCK_50),
                .srst_i (rst),
                .key_n_i(KEY[gi]),
                .press_o(press[gi])
            );
        end
    endgenerate

    // A cancel that lands on the EXEC cycle is replayed in SHOW
    assign cancel  = press[1] | cancel_pend_q;
    assign advance = press[0];

    // Sequencer next-state and operand/opcode load logic
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        cancel_pend_d = 1'b0;
        if (state_q == ST_EXEC) begin
            state_d       = ST_SHOW;
            cancel_pend_d = press[1];
        end else if (cancel) begin
            state_d = ST_LOAD_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (advance) begin
            case (state_q)
                ST_LOAD_A: begin
                    a_d     = form_operand(sw_sync_q);
                    state_d = ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    b_d     = form_operand(sw_sync_q);
                    state_d = ST_LOAD_OP;
                end
                ST_LOAD_OP: begin
                    op_d    = sw_sync_q[OPCODE_W-1:0];
                    state_d = ST_EXEC;
                end
                ST_SHOW:    state_d = ST_LOAD_A;
                default:    state_d = ST_LOAD_A;
            endcase
        end
    end

    // Switch synchronizer, FSM state and output registers
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            state_q       <= ST_LOAD_A;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            cancel_pend_q <= 1'b0;
        end else begin
            sw_meta_q     <= SW[16:0];
            sw_sync_q     <= sw_meta_q;
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            cancel_pend_q <= cancel_pend_d;
        end
    end

    // One-hot state display; EXEC shares the SHOW lamp
    always_comb begin
        state_led = 4'b0001;
        case (state_q)
            ST_LOAD_A:  state_led = 4'b0001;
            ST_LOAD_B:  state_led = 4'b0010;
            ST_LOAD_OP: state_led = 4'b0100;
            ST_EXEC:    state_led = 4'b1000;
            ST_SHOW:    state_led = 4'b1000;
            default:    state_led = 4'b0001;
        endcase
    end

    assign port_A     = a_q;
    assign port_B     = b_q;
    assign ALUOP      = op_q;
    assign exec_valid = (state_q == ST_EXEC);

endmodule
